// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling
// and a saturating stall counter.
module id_ex_stage #(
  parameter int unsigned DW        = 32,
  parameter logic [15:0] STALL_MAX = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    IF_ID_Rs,
  input  logic [4:0]    IF_ID_Rt,
  input  logic [4:0]    IF_ID_Rd,
  input  logic [DW-1:0] IF_ID_Imm32,
  input  logic [DW-1:0] IF_ID_PC4,
  input  logic [DW-1:0] busA,
  input  logic [DW-1:0] busB,
  input  logic          RegWr,
  input  logic          RegDst,
  input  logic          AluSrc,
  input  logic          MemWr,
  input  logic          MemRd,
  input  logic          MemtoReg,
  input  logic          Branch,
  input  logic [3:0]    AluCtr,
  input  logic          Flush,
  output logic [4:0]    ID_EX_Rs,
  output logic [4:0]    ID_EX_Rt,
  output logic [4:0]    ID_EX_Rd,
  output logic [DW-1:0] ID_EX_busA,
  output logic [DW-1:0] ID_EX_busB,
  output logic [DW-1:0] ID_EX_Imm32,
  output logic [DW-1:0] ID_EX_PC4,
  output logic          ID_EX_RegWr,
  output logic          ID_EX_RegDst,
  output logic          ID_EX_AluSrc,
  output logic          ID_EX_MemWr,
  output logic          ID_EX_MemRd,
  output logic          ID_EX_MemtoReg,
  output logic          ID_EX_Branch,
  output logic [3:0]    ID_EX_AluCtr,
  output logic          ID_EX_Valid,
  output logic          PcWrite,
  output logic          IF_ID_Write,
  output logic [15:0]   StallCnt
);

  typedef struct packed {
    logic       regwr;
    logic       regdst;
    logic       alusrc;
    logic       memwr;
    logic       memrd;
    logic       memtoreg;
    logic       branch;
    logic [3:0] aluctr;
    logic       valid;
  } ctrl_t;

  typedef struct packed {
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [DW-1:0] busa;
    logic [DW-1:0] busb;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
  } data_t;

  ctrl_t       ctrl_d, ctrl_q;
  data_t       data_d, data_q;
  logic [15:0] cnt_d, cnt_q;
  logic        load_use;
  logic        stall;

  // Valid gating keeps a bubble (or reset state) from ever matching.
  assign load_use = ctrl_q.memrd && ctrl_q.valid && (data_q.rt != 5'd0) &&
                    ((data_q.rt == IF_ID_Rs) || (data_q.rt == IF_ID_Rt));
  assign stall       = load_use && !Flush;
  assign PcWrite     = !stall;
  assign IF_ID_Write = !stall;

  always_comb begin
    ctrl_d.regwr    = RegWr;
    ctrl_d.regdst   = RegDst;
    ctrl_d.alusrc   = AluSrc;
    ctrl_d.memwr    = MemWr;
    ctrl_d.memrd    = MemRd;
    ctrl_d.memtoreg = MemtoReg;
    ctrl_d.branch   = Branch;
    ctrl_d.aluctr   = AluCtr;
    ctrl_d.valid    = 1'b1;
    data_d.rs       = IF_ID_Rs;
    data_d.rt       = IF_ID_Rt;
    data_d.rd       = IF_ID_Rd;
    data_d.busa     = busA;
    data_d.busb     = busB;
    data_d.imm      = IF_ID_Imm32;
    data_d.pc4      = IF_ID_PC4;
    cnt_d           = cnt_q;
    if (Flush) begin
      ctrl_d = '0;
      data_d = '0;
    end else if (load_use) begin
      ctrl_d = '0;
      data_d = data_q;
      if (cnt_q != STALL_MAX) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ID_EX_Rs       = data_q.rs;
  assign ID_EX_Rt       = data_q.rt;
  assign ID_EX_Rd       = data_q.rd;
  assign ID_EX_busA     = data_q.busa;
  assign ID_EX_busB     = data_q.busb;
  assign ID_EX_Imm32    = data_q.imm;
  assign ID_EX_PC4      = data_q.pc4;
  assign ID_EX_RegWr    = ctrl_q.regwr;
  assign ID_EX_RegDst   = ctrl_q.regdst;
  assign ID_EX_AluSrc   = ctrl_q.alusrc;
  assign ID_EX_MemWr    = ctrl_q.memwr;
  assign ID_EX_MemRd    = ctrl_q.memrd;
  assign ID_EX_MemtoReg = ctrl_q.memtoreg;
  assign ID_EX_Branch   = ctrl_q.branch;
  assign ID_EX_AluCtr   = ctrl_q.aluctr;
  assign ID_EX_Valid    = ctrl_q.valid;
  assign StallCnt       = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes model predictions,
// a monitor pops and compares them against the DUT each cycle.
module tb_id_ex_stage;
  localparam logic [15:0] SMAX = 16'd40;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm, pc4;
    logic        regwr, regdst, alusrc, memwr, memrd, memtoreg, branch;
    logic [3:0]  alu;
    logic        valid;
    logic [15:0] cnt;
  } st_t;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm, pc4;
    logic        regwr, regdst, alusrc, memwr, memrd, memtoreg, branch;
    logic [3:0]  alu;
    logic        flush;
  } in_t;

  typedef struct {
    logic pcw;
    st_t  st;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  IF_ID_Rs = '0, IF_ID_Rt = '0, IF_ID_Rd = '0;
  logic [31:0] IF_ID_Imm32 = '0, IF_ID_PC4 = '0, busA = '0, busB = '0;
  logic        RegWr = 1'b0, RegDst = 1'b0, AluSrc = 1'b0, MemWr = 1'b0;
  logic        MemRd = 1'b0, MemtoReg = 1'b0, Branch = 1'b0, Flush = 1'b0;
  logic [3:0]  AluCtr = '0;
  logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic [31:0] ID_EX_busA, ID_EX_busB, ID_EX_Imm32, ID_EX_PC4;
  logic        ID_EX_RegWr, ID_EX_RegDst, ID_EX_AluSrc, ID_EX_MemWr;
  logic        ID_EX_MemRd, ID_EX_MemtoReg, ID_EX_Branch, ID_EX_Valid;
  logic [3:0]  ID_EX_AluCtr;
  logic        PcWrite, IF_ID_Write;
  logic [15:0] StallCnt;

  id_ex_stage #(.DW(32), .STALL_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd),
    .IF_ID_Imm32(IF_ID_Imm32), .IF_ID_PC4(IF_ID_PC4),
    .busA(busA), .busB(busB),
    .RegWr(RegWr), .RegDst(RegDst), .AluSrc(AluSrc), .MemWr(MemWr),
    .MemRd(MemRd), .MemtoReg(MemtoReg), .Branch(Branch), .AluCtr(AluCtr),
    .Flush(Flush),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_busA(ID_EX_busA), .ID_EX_busB(ID_EX_busB),
    .ID_EX_Imm32(ID_EX_Imm32), .ID_EX_PC4(ID_EX_PC4),
    .ID_EX_RegWr(ID_EX_RegWr), .ID_EX_RegDst(ID_EX_RegDst),
    .ID_EX_AluSrc(ID_EX_AluSrc), .ID_EX_MemWr(ID_EX_MemWr),
    .ID_EX_MemRd(ID_EX_MemRd), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_Branch(ID_EX_Branch), .ID_EX_AluCtr(ID_EX_AluCtr),
    .ID_EX_Valid(ID_EX_Valid), .PcWrite(PcWrite), .IF_ID_Write(IF_ID_Write),
    .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  st_t got;
  assign got = {ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_busA, ID_EX_busB,
                ID_EX_Imm32, ID_EX_PC4, ID_EX_RegWr, ID_EX_RegDst,
                ID_EX_AluSrc, ID_EX_MemWr, ID_EX_MemRd, ID_EX_MemtoReg,
                ID_EX_Branch, ID_EX_AluCtr, ID_EX_Valid, StallCnt};

  int   nchk = 0;
  int   nfail = 0;
  exp_t q[$];
  st_t  m = '0;

  task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic drive(input in_t s);
    IF_ID_Rs = s.rs; IF_ID_Rt = s.rt; IF_ID_Rd = s.rd;
    busA = s.a; busB = s.b; IF_ID_Imm32 = s.imm; IF_ID_PC4 = s.pc4;
    RegWr = s.regwr; RegDst = s.regdst; AluSrc = s.alusrc; MemWr = s.memwr;
    MemRd = s.memrd; MemtoReg = s.memtoreg; Branch = s.branch;
    AluCtr = s.alu; Flush = s.flush;
  endtask

  function automatic logic hazard(input st_t ex, input in_t s);
    return ex.memrd && ex.valid && ex.rt != 5'd0 && (ex.rt == s.rs || ex.rt == s.rt);
  endfunction

  // Reference: what the EX-side view should be after the next rising edge.
  task automatic issue(input in_t s);
    exp_t        e;
    logic        lu;
    logic [15:0] c;
    @(negedge clk);
    drive(s);
    lu    = hazard(m, s);
    e.pcw = !(lu && !s.flush);
    if (s.flush) begin
      c = m.cnt; m = '0; m.cnt = c;
    end else if (lu) begin
      m.regwr = 0; m.regdst = 0; m.alusrc = 0; m.memwr = 0; m.memrd = 0;
      m.memtoreg = 0; m.branch = 0; m.alu = '0; m.valid = 0;
      if (m.cnt < SMAX) m.cnt = m.cnt + 16'd1;
    end else begin
      m.rs = s.rs; m.rt = s.rt; m.rd = s.rd; m.a = s.a; m.b = s.b;
      m.imm = s.imm; m.pc4 = s.pc4; m.regwr = s.regwr; m.regdst = s.regdst;
      m.alusrc = s.alusrc; m.memwr = s.memwr; m.memrd = s.memrd;
      m.memtoreg = s.memtoreg; m.branch = s.branch; m.alu = s.alu; m.valid = 1;
    end
    e.st = m;
    q.push_back(e);
  endtask

  function automatic in_t rnd();
    in_t s;
    s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
    s.rd = 5'($urandom); s.a = $urandom; s.b = $urandom;
    s.imm = $urandom; s.pc4 = $urandom;
    {s.regwr, s.regdst, s.alusrc, s.memwr, s.memrd, s.memtoreg, s.branch} = 7'($urandom);
    s.alu = 4'($urandom);
    s.flush = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Monitor: combinational stall outputs checked before the edge, registers after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("PcWrite", 192'(PcWrite), 192'(e.pcw));
        chk("IF_ID_Write", 192'(IF_ID_Write), 192'(e.pcw));
        @(posedge clk);
        #1;
        chk("id_ex_state", 192'(got), 192'(e.st));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in_t s;
    logic lu;
    #12;
    chk("reset_state", 192'(got), 192'(0));
    chk("reset_pcwrite", 192'(PcWrite), 192'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;

    s = '0; s.rs = 5; s.regwr = 1; s.alu = 4'h2; s.a = 32'h11;
    issue(s);
    s = '0; s.rt = 8; s.memrd = 1; s.regwr = 1; issue(s);
    s = '0; s.rs = 8; s.rd = 3; s.regwr = 1; issue(s);
    issue(s);
    s = '0; s.rt = 0; s.memrd = 1; issue(s);
    s = '0; s.rs = 0; s.regwr = 1; issue(s);
    s = '0; s.rt = 8; s.memrd = 1; issue(s);
    s = '0; s.rs = 8; s.flush = 1; issue(s);

    s = '0; s.rt = 9; s.memrd = 1; s.regwr = 1; issue(s);
    s = '0; s.rt = 9; s.rs = 9; s.regwr = 1;
    @(negedge clk);
    drive(s);
    lu = hazard(m, s);
    #3 chk("pre_reset_pcwrite", 192'(PcWrite), 192'(!lu));
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", 192'(got), 192'(0));
    chk("async_reset_pcwrite", 192'(PcWrite), 192'(1));
    m = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(s);

    for (int i = 0; i < 400; i++) issue(rnd());

    for (int i = 0; i < 50; i++) begin
      s = rnd(); s.flush = 0; s.memrd = 1; s.rt = 7; issue(s);
      s = rnd(); s.flush = 0; s.memrd = 0; s.rs = 7; issue(s);
      issue(s);
    end

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 192'(q.size()), 192'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DW, default 32, datapath width of register operands, immediate and PC+4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset; clears all registered state.
REQ-004 IF_ID_Rs, IF_ID_Rt, IF_ID_Rd  input  5 each  register fields of the instruction in decode.
REQ-005 IF_ID_Imm32, IF_ID_PC4  input  DW each  sign/zero-extended immediate; PC+4 of decode instruction.
REQ-006 busA, busB  input  DW each  register-file read data for Rs, Rt.
REQ-007 RegWr, RegDst, AluSrc, MemWr, MemRd, MemtoReg, Branch  input  1 each  decoded control.
REQ-008 AluCtr  input  4  decoded ALU operation.
REQ-009 Flush  input  1  taken branch/jump resolved downstream; kill the decode instruction.
REQ-010 ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  output  5 each  registered register fields (forwarding-unit compare inputs).
REQ-011 ID_EX_busA, ID_EX_busB, ID_EX_Imm32, ID_EX_PC4  output  DW each  registered operands.
REQ-012 ID_EX_RegWr, ID_EX_RegDst, ID_EX_AluSrc, ID_EX_MemWr, ID_EX_MemRd, ID_EX_MemtoReg, ID_EX_Branch  output  1 each  registered control.
REQ-013 ID_EX_AluCtr  output  4  registered ALU operation.
REQ-014 ID_EX_Valid  output  1  1 = real instruction in EX, 0 = bubble.
REQ-015 PcWrite, IF_ID_Write  output  1 each  combinational; 0 freezes PC / IF-ID register.
REQ-016 StallCnt  output  16  count of load-use stall cycles since reset.

Function
REQ-017 LoadUse SHALL be ID_EX_MemRd && ID_EX_Valid && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || ID_EX_Rt==IF_ID_Rt), evaluated combinationally.
REQ-018 On each rising clk edge with Flush=1: all ID_EX control outputs and ID_EX_Valid SHALL load 0; register/data fields load 0.
REQ-019 Else with LoadUse=1: same bubble as REQ-018 (control and Valid 0); data fields SHALL hold previous value.
REQ-020 Else: every ID_EX output SHALL load its corresponding input, ID_EX_Valid loads 1; latency exactly one cycle.
REQ-021 PcWrite and IF_ID_Write SHALL equal !(LoadUse && !Flush); Flush overrides stall so the redirect is taken.
REQ-022 Stall SHALL last exactly one cycle per load-use pair, since the bubble clears ID_EX_MemRd.
REQ-023 Register 0 SHALL never cause a stall, regardless of MemRd.
REQ-024 StallCnt SHALL increment by 1 on each edge where LoadUse=1 and Flush=0; saturates at 16'hFFFF (no wrap).
REQ-025 Simultaneous Flush and LoadUse: bubble inserted, StallCnt unchanged, PcWrite=IF_ID_Write=1.
REQ-026 A bubble SHALL have RegWr=0 and MemWr=0 so no architectural state changes downstream.

Reset
REQ-027 rst_n=0 SHALL immediately (no clk) force all ID_EX outputs, ID_EX_Valid and StallCnt to 0.
REQ-028 During reset PcWrite=IF_ID_Write=1 (LoadUse=0 since Valid=0).
REQ-029 First edge after rst_n deasserts SHALL capture inputs per REQ-020.
REQ-030 Reset asserted mid-stall SHALL abort the stall; no partial state retained.

Verification
REQ-031 Plain pass: RegWr=1, AluCtr=4'h2, IF_ID_Rs=5, busA=32'h11 -> next cycle ID_EX_RegWr=1, ID_EX_AluCtr=2, ID_EX_Rs=5, ID_EX_busA=32'h11, Valid=1.
REQ-032 Load-use: lw into Rt=8 in EX, decode uses Rs=8 -> PcWrite=IF_ID_Write=0 one cycle, next ID_EX_Valid=0, RegWr=0, StallCnt=1; following cycle instruction issues with Valid=1.
REQ-033 Load to $0 in EX, decode reads Rs=0 -> no stall, StallCnt stays 0.
REQ-034 Flush=1 with LoadUse=1 -> bubble, PcWrite=1, StallCnt unchanged.
REQ-035 Async reset pulse between clock edges with ID_EX_RegWr=1, StallCnt=3 -> outputs 0 before next edge.
REQ-036 Force 65535 stalls -> StallCnt holds 16'hFFFF on further stalls.
